vga_driver_param: RTL and testbench



---
 rtl/vga_pkg.sv | 64 ++++++
 rtl/vga_bar_gen.sv | 40 ++++
 rtl/vga_driver_param.sv | 147 ++++++++++++++
 tb/tb_vga_driver_param.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, RGB565 colour-bar constants and timing helpers
// for the parametrised VGA driver family.
package vga_pkg;

  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_H_DISP  = 640;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_DISP  = 480;
  localparam int unsigned DEF_V_FRONT = 10;

  localparam int unsigned CNT_W     = 11;
  localparam int unsigned CNT_LIMIT = 2048;
  localparam int unsigned LEAD_MAX  = 4;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB565_RED     = 16'hF800;
  localparam logic [15:0] RGB565_BLUE    = 16'h001F;
  localparam logic [15:0] RGB565_BLACK   = 16'h0000;

  function automatic int unsigned timing_total(
    input int unsigned sync_w,
    input int unsigned back_w,
    input int unsigned disp_w,
    input int unsigned front_w
  );
    return sync_w + back_w + disp_w + front_w;
  endfunction

  function automatic logic [15:0] bar_colour(input bar_e bar);
    logic [15:0] colour;
    colour = RGB565_BLACK;
    case (bar)
      BAR_WHITE:   colour = RGB565_WHITE;
      BAR_YELLOW:  colour = RGB565_YELLOW;
      BAR_CYAN:    colour = RGB565_CYAN;
      BAR_GREEN:   colour = RGB565_GREEN;
      BAR_MAGENTA: colour = RGB565_MAGENTA;
      BAR_RED:     colour = RGB565_RED;
      BAR_BLUE:    colour = RGB565_BLUE;
      BAR_BLACK:   colour = RGB565_BLACK;
      default:     colour = RGB565_BLACK;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_bar_gen.sv
// Eight vertical RGB565 colour bars across the active line; used only
// when VGA_TEST_PATTERN_EN is defined.
module vga_bar_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP = DEF_H_DISP
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        de,
  output logic [15:0] colour
);

  // Very narrow test modes still get one pixel per bar.
  localparam int unsigned BAR_W = ((H_DISP / 8) == 0) ? 1 : (H_DISP / 8);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  bar_e             bar_idx;
  logic [CNT_W-1:0] bar_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bar_idx <= BAR_WHITE;
      bar_cnt <= '0;
    end else if (!de) begin
      bar_idx <= BAR_WHITE;
      bar_cnt <= '0;
    end else if (bar_cnt == BAR_LAST) begin
      bar_idx <= bar_e'(bar_idx + 3'd1);
      bar_cnt <= '0;
    end else begin
      bar_cnt <= bar_cnt + 1'b1;
    end
  end

  always_comb begin
    colour = bar_colour(bar_idx);
  end

endmodule

// File: rtl/vga_driver_param.sv
// Parametrised VGA/LCD timing driver with request lead and frame_start.
// Optional colour-bar generator enabled by macro VGA_TEST_PATTERN_EN.
module vga_driver_param
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_DISP   = DEF_H_DISP,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_DISP   = DEF_V_DISP,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned RGB_W    = 16,
  parameter int unsigned REQ_LEAD = 1
) (
  input  logic             clk,
  input  logic             rstn,
`ifdef VGA_TEST_PATTERN_EN
  input  logic             test_en,
`endif
  input  logic [RGB_W-1:0] pixel_data,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             data_req,
  output logic [10:0]      pixel_xpos,
  output logic [10:0]      pixel_ypos,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = timing_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int unsigned V_TOTAL = timing_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int unsigned H_ACT   = H_SYNC + H_BACK;
  localparam int unsigned V_ACT   = V_SYNC + V_BACK;

  if (H_TOTAL > CNT_LIMIT) begin : g_err_htotal
    $error("vga_driver_param: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > CNT_LIMIT) begin : g_err_vtotal
    $error("vga_driver_param: V_TOTAL exceeds 2048");
  end
  if (REQ_LEAD > LEAD_MAX) begin : g_err_lead
    $error("vga_driver_param: REQ_LEAD above 4");
  end
  if (REQ_LEAD > H_ACT) begin : g_err_lead_act
    $error("vga_driver_param: REQ_LEAD exceeds H_SYNC+H_BACK");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Window bounds held one bit wider so a bound of exactly 2048 stays exact.
  localparam logic [CNT_W:0] HS_END    = (CNT_W+1)'(H_SYNC);
  localparam logic [CNT_W:0] VS_END    = (CNT_W+1)'(V_SYNC);
  localparam logic [CNT_W:0] DE_H_BEG  = (CNT_W+1)'(H_ACT);
  localparam logic [CNT_W:0] DE_H_END  = (CNT_W+1)'(H_ACT + H_DISP);
  localparam logic [CNT_W:0] REQ_H_BEG = (CNT_W+1)'(H_ACT - REQ_LEAD);
  localparam logic [CNT_W:0] REQ_H_END = (CNT_W+1)'(H_ACT + H_DISP - REQ_LEAD);
  localparam logic [CNT_W:0] DE_V_BEG  = (CNT_W+1)'(V_ACT);
  localparam logic [CNT_W:0] DE_V_END  = (CNT_W+1)'(V_ACT + V_DISP);

  localparam logic [CNT_W-1:0] REQ_X0 = CNT_W'(H_ACT - REQ_LEAD);
  localparam logic [CNT_W-1:0] REQ_Y0 = CNT_W'(V_ACT);

  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  logic [CNT_W:0] h_ext;
  logic [CNT_W:0] v_ext;
  logic           hs_act;
  logic           vs_act;
  logic           v_win;
  logic           de_h_win;
  logic           req_h_win;

  always_comb begin
    h_ext     = {1'b0, h_cnt};
    v_ext     = {1'b0, v_cnt};
    hs_act    = run && (h_ext < HS_END);
    vs_act    = run && (v_ext < VS_END);
    v_win     = (v_ext >= DE_V_BEG) && (v_ext < DE_V_END);
    de_h_win  = (h_ext >= DE_H_BEG) && (h_ext < DE_H_END);
    req_h_win = (h_ext >= REQ_H_BEG) && (h_ext < REQ_H_END);
  end

  always_comb begin
    vga_hs      = hs_act ? HS_POL : ~HS_POL;
    vga_vs      = vs_act ? VS_POL : ~VS_POL;
    vga_de      = run && v_win && de_h_win;
    data_req    = run && v_win && req_h_win;
    pixel_xpos  = data_req ? (h_cnt - REQ_X0) : '0;
    pixel_ypos  = data_req ? (v_cnt - REQ_Y0) : '0;
    frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  if (RGB_W != 16) begin : g_err_rgb_w
    $error("vga_driver_param: test pattern requires RGB_W of 16");
  end

  logic [15:0] bar_rgb;

  vga_bar_gen #(
    .H_DISP (H_DISP)
  ) u_bar_gen (
    .clk    (clk),
    .rstn   (rstn),
    .de     (vga_de),
    .colour (bar_rgb)
  );

  always_comb begin
    vga_rgb = '0;
    if (vga_de) begin
      vga_rgb = test_en ? RGB_W'(bar_rgb) : pixel_data;
    end
  end
`else
  always_comb begin
    vga_rgb = vga_de ? pixel_data : '0;
  end
`endif

endmodule

// File: tb/tb_vga_driver_param.sv
// Randomised self-checking bench for vga_driver_param: default timing,
// a REQ_LEAD=2 pipelined source, and a tiny mode with a mid-frame reset.
module tb_vga_driver_param;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        req;
    logic        fs;
    logic [10:0] x;
    logic [10:0] y;
    logic [15:0] rgb;
  } obs_t;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit BARS0 = 1'b1;
`else
  localparam bit BARS0 = 1'b0;
`endif

  localparam int N_CYC = 29000;

  logic clk = 1'b0;
  logic rstn;
  logic rstn_s;
  logic [15:0] pd0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] bar_ref [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // src: 0 = value on pd, 1 = ideal source returning the pixel column index
  function automatic obs_t model(input int hsy, input int hb, input int hd, input int hf,
                                 input int vsy, input int vb, input int vd, input int vf,
                                 input int lead, input bit hpol, input bit vpol,
                                 input bit run, input int t, input logic [15:0] pd,
                                 input bit src, input bit bars);
    obs_t o;
    int ht, vt, h, v, ha, va, bw;
    bit vwin;
    ht = hsy + hb + hd + hf;
    vt = vsy + vb + vd + vf;
    h  = run ? t % ht : 0;
    v  = run ? (t / ht) % vt : 0;
    ha = hsy + hb;
    va = vsy + vb;
    bw = (hd / 8 > 0) ? hd / 8 : 1;
    vwin  = (v >= va) && (v < va + vd);
    o.hs  = (run && h < hsy) ? hpol : !hpol;
    o.vs  = (run && v < vsy) ? vpol : !vpol;
    o.de  = run && vwin && h >= ha && h < ha + hd;
    o.req = run && vwin && h >= ha - lead && h < ha + hd - lead;
    o.fs  = run && h == 0 && v == 0;
    o.x   = o.req ? 11'(h - ha + lead) : 11'd0;
    o.y   = o.req ? 11'(v - va) : 11'd0;
    if (!o.de)     o.rgb = 16'h0;
    else if (bars) o.rgb = bar_ref[((h - ha) / bw) % 8];
    else if (src)  o.rgb = 16'(h - ha);
    else           o.rgb = pd;
    return o;
  endfunction

  // DUT 0: default 640x480 timing, REQ_LEAD=1, random source
  logic d0_hs, d0_vs, d0_de, d0_req, d0_fs;
  logic [10:0] d0_x, d0_y;
  logic [15:0] d0_rgb;

  vga_driver_param u_d0 (
    .clk         (clk),
    .rstn        (rstn),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (1'b1),
`endif
    .pixel_data  (pd0),
    .vga_hs      (d0_hs),
    .vga_vs      (d0_vs),
    .vga_de      (d0_de),
    .vga_rgb     (d0_rgb),
    .data_req    (d0_req),
    .pixel_xpos  (d0_x),
    .pixel_ypos  (d0_y),
    .frame_start (d0_fs)
  );

  // DUT 1: default timing, REQ_LEAD=2, two-stage registered source
  logic d1_hs, d1_vs, d1_de, d1_req, d1_fs;
  logic [10:0] d1_x, d1_y;
  logic [15:0] d1_rgb;
  logic [15:0] src1_a, src1_b;

  always @(posedge clk) begin
    src1_a <= {5'd0, d1_x};
    src1_b <= src1_a;
  end

  vga_driver_param #(
    .REQ_LEAD (2)
  ) u_d1 (
    .clk         (clk),
    .rstn        (rstn),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (1'b0),
`endif
    .pixel_data  (src1_b),
    .vga_hs      (d1_hs),
    .vga_vs      (d1_vs),
    .vga_de      (d1_de),
    .vga_rgb     (d1_rgb),
    .data_req    (d1_req),
    .pixel_xpos  (d1_x),
    .pixel_ypos  (d1_y),
    .frame_start (d1_fs)
  );

  // DUT 2: tiny mode, active-high hsync, own reset for the mid-frame pulse
  logic d2_hs, d2_vs, d2_de, d2_req, d2_fs;
  logic [10:0] d2_x, d2_y;
  logic [15:0] d2_rgb;

  vga_driver_param #(
    .H_SYNC   (2),
    .H_BACK   (2),
    .H_DISP   (4),
    .H_FRONT  (2),
    .V_SYNC   (1),
    .V_BACK   (1),
    .V_DISP   (3),
    .V_FRONT  (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b0),
    .REQ_LEAD (1)
  ) u_d2 (
    .clk         (clk),
    .rstn        (rstn_s),
`ifdef VGA_TEST_PATTERN_EN
    .test_en     (1'b0),
`endif
    .pixel_data  (pd0),
    .vga_hs      (d2_hs),
    .vga_vs      (d2_vs),
    .vga_de      (d2_de),
    .vga_rgb     (d2_rgb),
    .data_req    (d2_req),
    .pixel_xpos  (d2_x),
    .pixel_ypos  (d2_y),
    .frame_start (d2_fs)
  );

  initial begin
    bit run0, run1, run2;
    int t0, t1, t2;
    int rst_at;
    obs_t e0, e1, e2, g0, g1, g2, p0, p1, p2;
    int hs_fall = -1, hs_low = -1, hs_per = -1;
    int de_rise = -1, de_len = -1, de_first_t = -1;
    int vs_fall = -1, vs_low = -1, vs_per = -1;
    int fs_last = -1, fs_per = -1;
    bit req1_seen = 1'b0, de1_seen = 1'b0, restart_chk = 1'b0;

    rstn   = 1'b0;
    rstn_s = 1'b0;
    pd0    = 16'($urandom);
    run0 = 0; run1 = 0; run2 = 0;
    t0 = 0; t1 = 0; t2 = 0;
    rst_at = $urandom_range(300, 400);

    repeat (10) @(negedge clk);
    check("rst_hs", d0_hs, 1);
    check("rst_vs", d0_vs, 1);
    check("rst_de", d0_de, 0);
    check("rst_req", d0_req, 0);
    check("rst_fs", d0_fs, 0);
    check("rst_rgb", d0_rgb, 0);
    check("rst_hs_pol", d2_hs, 0);
    #2;
    rstn   = 1'b1;
    rstn_s = 1'b1;
    p0 = '0; p1 = '0; p2 = '0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk);
      if (!run0) begin run0 = 1; t0 = 0; end else t0++;
      if (!run1) begin run1 = 1; t1 = 0; end else t1++;
      if (!rstn_s) begin run2 = 0; t2 = 0; end
      else if (!run2) begin run2 = 1; t2 = 0; restart_chk = (cyc > rst_at); end
      else t2++;
      #1 pd0 = 16'($urandom);
      @(negedge clk);

      e0 = model(96, 48, 640, 16, 2, 33, 480, 10, 1, 0, 0, run0, t0, pd0, 0, BARS0);
      e1 = model(96, 48, 640, 16, 2, 33, 480, 10, 2, 0, 0, run1, t1, pd0, 1, 0);
      e2 = model(2, 2, 4, 2, 1, 1, 3, 1, 1, 1, 0, run2, t2, pd0, 0, 0);
      g0 = {d0_hs, d0_vs, d0_de, d0_req, d0_fs, d0_x, d0_y, d0_rgb};
      g1 = {d1_hs, d1_vs, d1_de, d1_req, d1_fs, d1_x, d1_y, d1_rgb};
      g2 = {d2_hs, d2_vs, d2_de, d2_req, d2_fs, d2_x, d2_y, d2_rgb};
      check("d0_cycle", g0, e0);
      check("d1_cycle", g1, e1);
      check("d2_cycle", g2, e2);

      if (cyc == 0) begin
        check("first_fs", d0_fs, 1);
        check("first_hs", d0_hs, 0);
      end
      if (restart_chk) begin
        check("restart_fs", d2_fs, 1);
        restart_chk = 1'b0;
      end

      // d0 line-level measurements
      if (p0.hs && !g0.hs) begin
        if (hs_fall >= 0) hs_per = cyc - hs_fall;
        hs_fall = cyc;
      end
      if (!p0.hs && g0.hs && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (!p0.de && g0.de) begin
        de_rise = cyc;
        if (de_first_t < 0) de_first_t = t0;
      end
      if (p0.de && !g0.de && de_rise >= 0) de_len = cyc - de_rise;

      // d1 request lead
      if (!p1.req && g1.req && !req1_seen) begin
        req1_seen = 1'b1;
        check("req_rise_h", t1 % 800, 142);
        check("req_rise_x", d1_x, 0);
      end
      if (!p1.de && g1.de && !de1_seen) begin
        de1_seen = 1'b1;
        check("de_rise_rgb", d1_rgb, 0);
      end
      if (t1 == 35 * 800 + 781) check("req_x639", d1_x, 639);
      if (t1 == 35 * 800 + 783) check("rgb_783", d1_rgb, 639);

      // d2 frame-level measurements
      if (p2.vs && !g2.vs) begin
        if (vs_fall >= 0) vs_per = cyc - vs_fall;
        vs_fall = cyc;
      end
      if (!p2.vs && g2.vs && vs_fall >= 0) vs_low = cyc - vs_fall;
      if (g2.fs) begin
        if (fs_last >= 0) fs_per = cyc - fs_last;
        fs_last = cyc;
      end

      p0 = g0; p1 = g1; p2 = g2;

      if (cyc == rst_at) begin
        #2 rstn_s = 1'b0;
        run2 = 0; t2 = 0;
        #1;
        e2 = model(2, 2, 4, 2, 1, 1, 3, 1, 1, 1, 0, 0, 0, pd0, 0, 0);
        g2 = {d2_hs, d2_vs, d2_de, d2_req, d2_fs, d2_x, d2_y, d2_rgb};
        check("rst_async", g2, e2);
        p2 = g2;
        vs_fall = -1; fs_last = -1;
      end
      if (cyc == rst_at + 2) #2 rstn_s = 1'b1;
    end

    check("hs_low", hs_low, 96);
    check("hs_period", hs_per, 800);
    check("de_first_t", de_first_t, 35 * 800 + 144);
    check("de_len", de_len, 640);
    check("vs2_low", vs_low, 10);
    check("vs2_period", vs_per, 60);
    check("fs2_period", fs_per, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
